// File: rtl/dsk_pkg.sv
// Shared definitions for the disk-image sector path: sector geometry, fetch FSM
// encoding and the per-drive image base offsets applied by the address controller.
package dsk_pkg;
    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_WORDS = SECTOR_BYTES / 2;
    localparam int ADDR_W       = 22;

    localparam logic [ADDR_W-1:0] INT_IMG_BASE = 22'h100000;
    localparam logic [ADDR_W-1:0] EXT_IMG_BASE = 22'h200000;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetchState_t;
endpackage

// File: rtl/dsk_sector_fetch_if.sv
// Bundle of the RAM extra-slot read port, the request controls and the byte stream
// between a sector fetcher (slave) and the address controller / IWM side (master).
interface dsk_sector_fetch_if #(
    parameter int BLOCK_W = 11
);
    import dsk_pkg::*;

    logic              memoryLatch;
    logic              dskReadAck;
    logic [15:0]       memData;
    logic [ADDR_W-1:0] dskReadAddr;
    logic              req_start;
    logic [BLOCK_W-1:0] req_block;
    logic              req_abort;
    logic              busy;
    logic              done;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  memoryLatch, dskReadAck, memData, req_start, req_block, req_abort, out_ready,
        output dskReadAddr, busy, done, out_data, out_valid
    );

    modport master (
        output memoryLatch, dskReadAck, memData, req_start, req_block, req_abort, out_ready,
        input  dskReadAddr, busy, done, out_data, out_valid
    );
endinterface

// File: rtl/word_fifo.sv
// Small synchronous FIFO with flush; push and pop may occur on the same clock.
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     _reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    // Extra pointer bit distinguishes full from empty.
    assign level = wrPtr - rdPtr;
    assign empty = (wrPtr == rdPtr);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rdata = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) mem[wrPtr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) wrPtr <= wrPtr + 1'b1;
            if (pop && !empty) rdPtr <= rdPtr + 1'b1;
        end
    end
endmodule

// File: rtl/dsk_sector_fetch.sv
// Fetches one 512-byte sector through the extra RAM slot and streams it out
// big-endian, one byte per valid/ready handshake.
module dsk_sector_fetch
    import dsk_pkg::*;
#(
    parameter int BLOCK_W    = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              _reset,
    dsk_sector_fetch_if.slave bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    fetchState_t        state;
    logic [8:0]         wordCnt;
    logic               byteSel;
    logic [15:0]        headWord;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [LVL_W-1:0]   fifoLevel;
    logic [BLOCK_W-1:0] startBlock;
    logic               grant;
    logic               push;
    logic               handshake;
    logic               pop;
    logic               lastPop;

    assign startBlock = bus.req_block;
    assign grant      = bus.memoryLatch && bus.dskReadAck;
    // A full FIFO skips the slot; the address is held so the word is re-read later.
    assign push       = (state == FETCH) && grant && !fifoFull && !bus.req_abort;
    assign handshake  = bus.out_valid && bus.out_ready;
    assign pop        = handshake && byteSel;
    assign lastPop    = (state == DRAIN) && pop && (fifoLevel == LVL_W'(1)) && !bus.req_abort;

    assign bus.out_valid = !fifoEmpty;
    assign bus.out_data  = fifoEmpty ? 8'h00 : (byteSel ? headWord[7:0] : headWord[15:8]);

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk    (clk),
        ._reset (_reset),
        .flush  (bus.req_abort),
        .push   (push),
        .wdata  (bus.memData),
        .pop    (pop),
        .rdata  (headWord),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (fifoLevel)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state           <= IDLE;
            bus.dskReadAddr <= '0;
            wordCnt         <= '0;
            byteSel         <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (bus.req_abort) begin
                state    <= IDLE;
                wordCnt  <= '0;
                byteSel  <= 1'b0;
                bus.busy <= 1'b0;
            end else begin
                if (handshake) byteSel <= !byteSel;
                unique case (state)
                    IDLE: if (bus.req_start) begin
                        state           <= FETCH;
                        bus.dskReadAddr <= ADDR_W'({startBlock, 9'h000});
                        wordCnt         <= '0;
                        bus.busy        <= 1'b1;
                    end
                    FETCH: if (push) begin
                        wordCnt <= wordCnt + 9'd1;
                        // Last word leaves the address on the sector's final word.
                        if (wordCnt == 9'(SECTOR_WORDS - 1)) state <= DRAIN;
                        else bus.dskReadAddr <= bus.dskReadAddr + ADDR_W'(2);
                    end
                    DRAIN: if (lastPop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dsk_sector_fetch.sv
// Scoreboard bench: a RAM slot model returns data equal to the read address, the
// expected byte stream for each accepted sector is queued and checked by a monitor.
module tb_dsk_sector_fetch;
    localparam int BW = 11;

    logic clk = 1'b0;
    logic _reset;
    always #5 clk = ~clk;

    dsk_sector_fetch_if #(.BLOCK_W(BW)) bus ();

    dsk_sector_fetch #(.BLOCK_W(BW), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] expQ[$];
    int bytesSeen = 0;
    int doneSeen = 0;
    int slotGap = 16;
    int readyMode = 0;
    bit ctlEvent = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sector b is words (b*512 + 2n) & 0xFFFF, high byte first.
    task automatic queueSector(input int blk);
        logic [31:0] w;
        for (int n = 0; n < 256; n++) begin
            w = (blk * 512 + 2 * n) & 32'hFFFF;
            expQ.push_back(w[15:8]);
            expQ.push_back(w[7:0]);
        end
    endtask

    // RAM: one granted clk8 every slotGap clk8; latch on phase 3; data = address.
    initial begin
        logic [21:0] a0;
        bit stab;
        bit g;
        a0 = '0;
        stab = 1'b0;
        bus.memoryLatch = 1'b0;
        bus.dskReadAck  = 1'b0;
        bus.memData     = '0;
        forever begin
            for (int s = 0; s < slotGap; s++) begin
                g = (s == slotGap - 1);
                for (int p = 0; p < 4; p++) begin
                    @(posedge clk); #1;
                    bus.dskReadAck  = g;
                    bus.memoryLatch = (p == 3);
                    bus.memData     = g ? bus.dskReadAddr[15:0] : 16'($urandom);
                    if (g && p == 0) begin
                        a0 = bus.dskReadAddr;
                        stab = bus.busy;
                        ctlEvent = 1'b0;
                    end
                    if (g && p == 3 && stab && !ctlEvent && _reset)
                        chk("addr_stable_in_ack", 32'(bus.dskReadAddr), 32'(a0));
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (readyMode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: every handshake pops one expected byte; done must follow the last one.
    initial begin
        forever begin
            @(negedge clk);
            if (_reset === 1'b1 && bus.done === 1'b1) begin
                doneSeen++;
                chk("queue_empty_at_done", 32'(expQ.size()), 32'd0);
                chk("busy_low_at_done", 32'(bus.busy), 32'd0);
            end
            if (_reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_byte: got 0x%0h expected no byte at %0t", bus.out_data, $time);
                end else begin
                    chk("stream_byte", 32'(bus.out_data), 32'(expQ.pop_front()));
                end
                bytesSeen++;
            end
        end
    end

    task automatic startXfer(input int blk, input bit accept);
        @(posedge clk); #1;
        bus.req_start = 1'b1;
        bus.req_block = BW'(blk);
        if (accept) begin
            ctlEvent = 1'b1;
            queueSector(blk);
        end
        @(posedge clk); #1;
        bus.req_start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int maxCyc, input string name);
        int c;
        c = 0;
        while (doneSeen < target && c < maxCyc) begin
            @(posedge clk); #1;
            c++;
        end
        chk(name, 32'(doneSeen), 32'(target));
    endtask

    task automatic finishCheck(input int blk, input int doneTarget, input string name);
        repeat (10) @(posedge clk);
        #1;
        chk({name, "_single_done"}, 32'(doneSeen), 32'(doneTarget));
        chk({name, "_end_addr"}, 32'(bus.dskReadAddr), 32'(blk * 512 + 'h1FE));
        chk({name, "_queue_drained"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int base;
        int c;
        int doneBefore;
        logic [21:0] holdAddr;
        int rblk;

        bus.req_start = 1'b0;
        bus.req_block = '0;
        bus.req_abort = 1'b0;
        _reset = 1'b1;
        #2 _reset = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_addr", 32'(bus.dskReadAddr), 32'd0);
        repeat (3) @(negedge clk);
        _reset = 1'b1;

        // 1: block 3, consumer always ready, sparse slots
        readyMode = 0;
        base = bytesSeen;
        startXfer(3, 1'b1);
        chk("t1_start_addr", 32'(bus.dskReadAddr), 32'h600);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        waitDone(1, 17500, "t1_done");
        finishCheck(3, 1, "t1");
        chk("t1_byte_count", 32'(bytesSeen - base), 32'd512);

        // 2: back-pressure until FIFO full, forcing skipped slots
        slotGap = 2;
        readyMode = 1;
        base = bytesSeen;
        startXfer(3, 1'b1);
        c = 0;
        while (bus.out_valid !== 1'b1 && c < 500) begin @(posedge clk); #1; c++; end
        chk("t2_first_valid", 32'(bus.out_valid), 32'd1);
        repeat (80) @(posedge clk);
        readyMode = 0;
        waitDone(2, 6000, "t2_done");
        finishCheck(3, 2, "t2");
        chk("t2_byte_count", 32'(bytesSeen - base), 32'd512);

        // 3: abort after 100 bytes, restart at block 0
        readyMode = 2;
        base = bytesSeen;
        startXfer('h155, 1'b1);
        c = 0;
        while (bytesSeen < base + 100 && c < 3000) begin @(posedge clk); #1; c++; end
        chk("t3_reached_100", 32'(bytesSeen >= base + 100), 32'd1);
        readyMode = 1;
        bus.req_abort = 1'b1;
        ctlEvent = 1'b1;
        holdAddr = bus.dskReadAddr;
        doneBefore = doneSeen;
        @(posedge clk); #1;
        bus.req_abort = 1'b0;
        expQ.delete();
        chk("t3_valid_after_abort", 32'(bus.out_valid), 32'd0);
        chk("t3_addr_held", 32'(bus.dskReadAddr), 32'(holdAddr));
        readyMode = 2;
        startXfer(0, 1'b1);
        chk("t3_restart_addr", 32'(bus.dskReadAddr), 32'd0);
        chk("t3_restart_busy", 32'(bus.busy), 32'd1);
        waitDone(doneBefore + 1, 6000, "t3_done");
        finishCheck(0, doneBefore + 1, "t3");

        // 4: a start while busy is ignored
        doneBefore = doneSeen;
        startXfer('h2A, 1'b1);
        repeat (300) @(posedge clk);
        startXfer('h7F0, 1'b0);
        waitDone(doneBefore + 1, 6000, "t4_done");
        finishCheck('h2A, doneBefore + 1, "t4");

        // 5: asynchronous reset mid-fetch
        startXfer('h40, 1'b1);
        repeat (200) @(posedge clk);
        #3;
        _reset = 1'b0;
        ctlEvent = 1'b1;
        #1;
        chk("t5_async_busy", 32'(bus.busy), 32'd0);
        chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_async_data", 32'(bus.out_data), 32'd0);
        chk("t5_async_addr", 32'(bus.dskReadAddr), 32'd0);
        chk("t5_async_done", 32'(bus.done), 32'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #3;
        _reset = 1'b1;
        doneBefore = doneSeen;
        repeat (80) @(posedge clk);
        #1;
        chk("t5_idle_addr", 32'(bus.dskReadAddr), 32'd0);
        chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_idle_busy", 32'(bus.busy), 32'd0);

        // 6: top block of the window
        startXfer('h7FF, 1'b1);
        waitDone(doneBefore + 1, 6000, "t6_done");
        finishCheck('h7FF, doneBefore + 1, "t6");
        chk("t6_no_carry_bit20", 32'(bus.dskReadAddr[20]), 32'd0);

        // random blocks with random back-pressure
        for (int k = 0; k < 2; k++) begin
            rblk = $urandom_range(0, 2047);
            doneBefore = doneSeen;
            startXfer(rblk, 1'b1);
            waitDone(doneBefore + 1, 6000, "rand_done");
            finishCheck(rblk, doneBefore + 1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
